// File: rtl/seq_pkg.sv
// Shared types and constants for the LED/ADC sequencer.
package seq_pkg;

  localparam int ADC_W_DEF = 8;
  localparam logic [ADC_W_DEF-1:0] ADC_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    IR_SETTLE,
    IR_SAMPLE,
    RED_SETTLE,
    RED_SAMPLE,
    DARK_SETTLE,
    DARK_SAMPLE,
    WAIT
  } seq_state_t;

  function automatic int min_frame_cyc(input int settle_cyc);
    return 3 * (settle_cyc + 1) + 1;
  endfunction

endpackage

// File: rtl/led_adc_sequencer_sat_sub.sv
// Combinational unsigned subtract that clamps at zero instead of wrapping.
module sat_sub #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  assign y = (a > b) ? (a - b) : '0;

endmodule

// File: rtl/led_adc_sequencer.sv
// Time-multiplexed IR/RED LED drive with one shared-ADC sample per phase and per-frame publish.
// AMBIENT_SUB_EN adds a dark phase whose sample is subtracted from both channels.
module led_adc_sequencer
  import seq_pkg::*;
#(
  parameter int ADC_W      = ADC_W_DEF,
  parameter int SETTLE_CYC = 4,
  parameter int FRAME_CYC  = 20
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             enable,
  input  logic             hold,
  input  logic [ADC_W-1:0] ADC,
  output logic             LED_IR,
  output logic             LED_RED,
  output logic [ADC_W-1:0] IR_ADC_Value,
  output logic [ADC_W-1:0] RED_ADC_Value,
  output logic             sat_ir,
  output logic             sat_red,
  output logic             sample_valid,
  output logic             busy
);

  if (SETTLE_CYC < 1) begin : g_bad_settle
    $error("led_adc_sequencer: SETTLE_CYC must be at least 1");
  end
  if (FRAME_CYC < min_frame_cyc(SETTLE_CYC)) begin : g_bad_frame
    $error("led_adc_sequencer: FRAME_CYC too small for SETTLE_CYC");
  end

  localparam int CNT_W = $clog2(FRAME_CYC);
  localparam logic [CNT_W-1:0] IR_END   = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] RED_END  = CNT_W'(2 * SETTLE_CYC);
  localparam logic [CNT_W-1:0] LAST_CYC = CNT_W'(FRAME_CYC - 1);
  localparam logic [ADC_W-1:0] ALL_ONES = '1;

  seq_state_t       state, state_nxt;
  logic [CNT_W-1:0] frame_cnt;
  logic [ADC_W-1:0] ir_raw;
  logic [ADC_W-1:0] ir_res, red_res;
  logic             sat_red_res;
  logic             publish;

  // The last sample of a frame is taken on the same edge that publishes, so it
  // is consumed straight from ADC rather than from a raw register.
`ifdef AMBIENT_SUB_EN
  localparam logic [CNT_W-1:0] DARK_END = CNT_W'(3 * SETTLE_CYC + 1);
  logic [ADC_W-1:0] red_raw;

  sat_sub #(.W(ADC_W)) u_sub_ir  (.a(ir_raw),  .b(ADC), .y(ir_res));
  sat_sub #(.W(ADC_W)) u_sub_red (.a(red_raw), .b(ADC), .y(red_res));

  assign sat_red_res = (red_raw == ALL_ONES);
  assign publish     = (state == DARK_SAMPLE) && (state_nxt == WAIT);
`else
  assign ir_res      = ir_raw;
  assign red_res     = ADC;
  assign sat_red_res = (ADC == ALL_ONES);
  assign publish     = (state == RED_SAMPLE) && (state_nxt == WAIT);
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:        if (enable && !hold) state_nxt = IR_SETTLE;
      IR_SETTLE:   if (frame_cnt == IR_END) state_nxt = IR_SAMPLE;
      IR_SAMPLE:   state_nxt = RED_SETTLE;
      RED_SETTLE:  if (frame_cnt == RED_END) state_nxt = RED_SAMPLE;
`ifdef AMBIENT_SUB_EN
      RED_SAMPLE:  state_nxt = DARK_SETTLE;
      DARK_SETTLE: if (frame_cnt == DARK_END) state_nxt = DARK_SAMPLE;
      DARK_SAMPLE: state_nxt = WAIT;
`else
      RED_SAMPLE:  state_nxt = WAIT;
`endif
      WAIT:        if (frame_cnt == LAST_CYC && !hold) state_nxt = IR_SETTLE;
      default:     state_nxt = IDLE;
    endcase
    if (state != IDLE && !enable) state_nxt = IDLE;
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      frame_cnt <= '0;
    end else begin
      state <= state_nxt;
      if ((state_nxt == IR_SETTLE && state != IR_SETTLE) || state_nxt == IDLE)
        frame_cnt <= '0;
      else if (frame_cnt != LAST_CYC)
        frame_cnt <= frame_cnt + 1'b1;
    end
  end

  // LEDs are decoded from the next state so the registered pins track the current state exactly.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      LED_IR        <= 1'b0;
      LED_RED       <= 1'b0;
      sample_valid  <= 1'b0;
      ir_raw        <= '0;
      IR_ADC_Value  <= '0;
      RED_ADC_Value <= '0;
      sat_ir        <= 1'b0;
      sat_red       <= 1'b0;
`ifdef AMBIENT_SUB_EN
      red_raw       <= '0;
`endif
    end else begin
      LED_IR       <= (state_nxt == IR_SETTLE)  || (state_nxt == IR_SAMPLE);
      LED_RED      <= (state_nxt == RED_SETTLE) || (state_nxt == RED_SAMPLE);
      sample_valid <= publish;
      if (state == IR_SAMPLE) ir_raw <= ADC;
`ifdef AMBIENT_SUB_EN
      if (state == RED_SAMPLE) red_raw <= ADC;
`endif
      if (publish) begin
        IR_ADC_Value  <= ir_res;
        RED_ADC_Value <= red_res;
        sat_ir        <= (ir_raw == ALL_ONES);
        sat_red       <= sat_red_res;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_led_adc_sequencer.sv
// Directed, table-driven bench for led_adc_sequencer (works with or without AMBIENT_SUB_EN).
module tb_led_adc_sequencer;

  localparam int S = 4;
  localparam int F = 20;
`ifdef AMBIENT_SUB_EN
  localparam int VC = 3 * (S + 1);
`else
  localparam int VC = 2 * (S + 1);
`endif

  logic       CLK = 1'b0;
  logic       rst, enable, hold;
  logic [7:0] ADC;
  logic       LED_IR, LED_RED, sat_ir, sat_red, sample_valid, busy;
  logic [7:0] IR_ADC_Value, RED_ADC_Value;

  led_adc_sequencer #(.ADC_W(8), .SETTLE_CYC(S), .FRAME_CYC(F)) dut (
    .CLK(CLK), .rst(rst), .enable(enable), .hold(hold), .ADC(ADC),
    .LED_IR(LED_IR), .LED_RED(LED_RED),
    .IR_ADC_Value(IR_ADC_Value), .RED_ADC_Value(RED_ADC_Value),
    .sat_ir(sat_ir), .sat_red(sat_red), .sample_valid(sample_valid), .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] ir, red, dark;
    logic [7:0] sub_ir, sub_red;
    logic       s_ir, s_red;
  } vec_t;

  vec_t vecs[6];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cur_frame = 0;
  int   cur_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (frame %0d cycle %0d): got %0h, expected %0h",
               name, cur_frame, cur_cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [7:0] exp_ir(input vec_t v);
`ifdef AMBIENT_SUB_EN
    return v.sub_ir;
`else
    return v.ir;
`endif
  endfunction

  function automatic logic [7:0] exp_red(input vec_t v);
`ifdef AMBIENT_SUB_EN
    return v.sub_red;
`else
    return v.red;
`endif
  endfunction

  // Plays one whole frame starting in its cycle 0; leaves time at the following cycle.
  task automatic run_frame(input vec_t v, input int hold_at);
    for (int c = 0; c < F; c++) begin
      cur_cyc = c;
      ADC = (c <= S) ? v.ir : (c <= 2 * S + 1) ? v.red : (c <= 3 * S + 2) ? v.dark : 8'h00;
      check("led_ir", 32'(LED_IR), 32'(c <= S));
      check("led_red", 32'(LED_RED), 32'(c > S && c <= 2 * S + 1));
      check("sample_valid", 32'(sample_valid), 32'(c == VC));
      check("busy", 32'(busy), 32'd1);
      if (c == VC) begin
        check("ir_value", 32'(IR_ADC_Value), 32'(exp_ir(v)));
        check("red_value", 32'(RED_ADC_Value), 32'(exp_red(v)));
        check("sat_ir", 32'(sat_ir), 32'(v.s_ir));
        check("sat_red", 32'(sat_red), 32'(v.s_red));
      end
      if (c == hold_at) hold = 1'b1;
      tick();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_led_ir"}, 32'(LED_IR), 32'd0);
    check({tag, "_led_red"}, 32'(LED_RED), 32'd0);
    check({tag, "_ir_value"}, 32'(IR_ADC_Value), 32'd0);
    check({tag, "_red_value"}, 32'(RED_ADC_Value), 32'd0);
    check({tag, "_sat"}, 32'({sat_ir, sat_red}), 32'd0);
    check({tag, "_valid"}, 32'(sample_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    vec_t hv;
    int   pulses;

    //          ir     red    dark   sub_ir sub_red sat_ir sat_red
    vecs[0] = '{8'hC0, 8'h80, 8'h10, 8'hB0, 8'h70, 1'b0, 1'b0};
    vecs[1] = '{8'h05, 8'h90, 8'h20, 8'h00, 8'h70, 1'b0, 1'b0};
    vecs[2] = '{8'hFF, 8'h40, 8'h10, 8'hEF, 8'h30, 1'b1, 1'b0};
    vecs[3] = '{8'h40, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[4] = '{8'h33, 8'h00, 8'h00, 8'h33, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{8'hFF, 8'hFF, 8'h00, 8'hFF, 8'hFF, 1'b1, 1'b1};

    rst = 1'b1; enable = 1'b0; hold = 1'b0; ADC = 8'h00;
    #12;
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 32'd0);
    enable = 1'b1;
    tick();

    // Back-to-back frames: each new frame must start exactly F cycles after the last.
    for (int i = 0; i < 6; i++) begin
      cur_frame = i;
      run_frame(vecs[i], -1);
    end

    // Enable dropped in frame cycle 7: abort to IDLE, keep previous results.
    cur_frame = 6;
    for (int c = 0; c <= 7; c++) begin
      cur_cyc = c;
      ADC = 8'h11;
      if (c == 7) begin
        check("abort_led_red_before", 32'(LED_RED), 32'd1);
        enable = 1'b0;
      end
      tick();
    end
    cur_cyc = 8;
    check("abort_led_red", 32'(LED_RED), 32'd0);
    check("abort_led_ir", 32'(LED_IR), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ir_value", 32'(IR_ADC_Value), 32'(exp_ir(vecs[5])));
    check("abort_red_value", 32'(RED_ADC_Value), 32'(exp_red(vecs[5])));
    check("abort_sat", 32'({sat_ir, sat_red}), 32'd3);
    pulses = 0;
    for (int c = 0; c < 25; c++) begin
      if (sample_valid) pulses++;
      tick();
    end
    check("abort_valid_pulses", 32'(pulses), 32'd0);

    // Hold raised at frame cycle 3: frame still completes, then parks in WAIT.
    cur_frame = 7;
    enable = 1'b1;
    tick();
    hv = '{8'h50, 8'h30, 8'h10, 8'h40, 8'h20, 1'b0, 1'b0};
    run_frame(hv, 3);
    for (int c = 0; c < 5; c++) begin
      cur_cyc = F + c;
      check("hold_led_ir", 32'(LED_IR), 32'd0);
      check("hold_led_red", 32'(LED_RED), 32'd0);
      check("hold_busy", 32'(busy), 32'd1);
      check("hold_valid", 32'(sample_valid), 32'd0);
      if (c < 4) tick();
    end
    hold = 1'b0;
    tick();
    cur_frame = 8; cur_cyc = 0;
    check("release_led_ir", 32'(LED_IR), 32'd1);
    check("release_busy", 32'(busy), 32'd1);

    // Asynchronous reset in frame cycle 2 clears everything without waiting for a clock edge.
    tick();
    tick();
    cur_cyc = 2;
    check("pre_reset_led_ir", 32'(LED_IR), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    tick();
    rst = 1'b0;
    enable = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
